// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result bundle for serial_subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf, zero
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - bin, STEP bits per cycle LSB first, with borrow/overflow/zero flags.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_badParams
      $error("serial_subtractor: STEP must be at least 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic             w_accept;
  logic             w_lastChunk;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;
  logic [CW-1:0]    r_cnt;
  logic [STEP:0]    w_ripple;
  logic [STEP-1:0]  w_chunkDiff;
  logic [WIDTH-1:0] w_shiftNext;

  assign w_lastChunk = (r_state == S_RUN) && (r_cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_stateNext = S_RUN;
        end
      end
      S_RUN: begin
        if (w_lastChunk) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_stateNext = S_RUN;
        end else begin
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Ripple of STEP full-subtractor cells; w_ripple[i] is the borrow into bit i of the chunk.
  always_comb begin
    w_ripple    = '0;
    w_chunkDiff = '0;
    w_ripple[0] = r_borrow;
    for (int i = 0; i < STEP; i++) begin
      w_chunkDiff[i] = r_a[i] ^ r_b[i] ^ w_ripple[i];
      w_ripple[i+1]  = (~r_a[i] & r_b[i]) | (~(r_a[i] ^ r_b[i]) & w_ripple[i]);
    end
  end

  assign w_shiftNext = (r_shift >> STEP) | (WIDTH'(w_chunkDiff) << (WIDTH - STEP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_shift  <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a      <= bus.a;
        r_b      <= bus.b;
        r_borrow <= bus.bin;
        r_cnt    <= '0;
        r_shift  <= '0;
      end else if (r_state == S_RUN) begin
        r_a      <= r_a >> STEP;
        r_b      <= r_b >> STEP;
        r_borrow <= w_ripple[STEP];
        r_shift  <= w_shiftNext;
        r_cnt    <= r_cnt + 1'b1;
      end
      // The last chunk holds the MSB, so its ripple gives both borrows needed for ovf.
      if (w_lastChunk) begin
        r_diff <= w_shiftNext;
        r_bout <= w_ripple[STEP];
        r_ovf  <= w_ripple[STEP-1] ^ w_ripple[STEP];
        r_zero <= (w_shiftNext == '0);
      end
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = (r_state == S_DONE);
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
  assign bus.ovf  = r_ovf;
  assign bus.zero = r_zero;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three configurations, fixed vectors, corner sequences and random ops.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8s1 ();
  serial_subtractor_if #(.WIDTH(1)) bus1s1 ();
  serial_subtractor_if #(.WIDTH(8)) bus8s4 ();

  serial_subtractor #(.WIDTH(8), .STEP(1)) dut8s1 (.clk(clk), .rst_n(rst_n), .bus(bus8s1));
  serial_subtractor #(.WIDTH(1), .STEP(1)) dut1s1 (.clk(clk), .rst_n(rst_n), .bus(bus1s1));
  serial_subtractor #(.WIDTH(8), .STEP(4)) dut8s4 (.clk(clk), .rst_n(rst_n), .bus(bus8s4));

  typedef struct {
    int         sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;
    int         cycles;
  } vec_t;

  vec_t       vecs [12];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] gotDiff;
  logic       gotBout, gotOvf, gotZero, gotDone, diffMoved, overlap;
  int         gotCycles, gotBusy;

  function automatic int widthOf(input int sel);
    return (sel == 1) ? 1 : 8;
  endfunction

  function automatic int latencyOf(input int sel);
    case (sel)
      0:       return 8;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic rdBusy(input int sel);
    case (sel)
      0:       return bus8s1.busy;
      1:       return bus1s1.busy;
      default: return bus8s4.busy;
    endcase
  endfunction

  function automatic logic rdDone(input int sel);
    case (sel)
      0:       return bus8s1.done;
      1:       return bus1s1.done;
      default: return bus8s4.done;
    endcase
  endfunction

  function automatic logic [7:0] rdDiff(input int sel);
    case (sel)
      0:       return bus8s1.diff;
      1:       return {7'b0, bus1s1.diff};
      default: return bus8s4.diff;
    endcase
  endfunction

  function automatic logic [2:0] rdFlags(input int sel);
    case (sel)
      0:       return {bus8s1.bout, bus8s1.ovf, bus8s1.zero};
      1:       return {bus1s1.bout, bus1s1.ovf, bus1s1.zero};
      default: return {bus8s4.bout, bus8s4.ovf, bus8s4.zero};
    endcase
  endfunction

  task automatic driveIn(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b,
                         input logic bin);
    case (sel)
      0: begin
        bus8s1.start = st; bus8s1.a = a; bus8s1.b = b; bus8s1.bin = bin;
      end
      1: begin
        bus1s1.start = st; bus1s1.a = a[0]; bus1s1.b = b[0]; bus1s1.bin = bin;
      end
      default: begin
        bus8s4.start = st; bus8s4.a = a; bus8s4.b = b; bus8s4.bin = bin;
      end
    endcase
  endtask

  // Arithmetic reference: unsigned difference for diff/bout, signed range test for ovf.
  task automatic refModel(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output logic [7:0] d, output logic bo, output logic ov, output logic z);
    int mask, half, ai, bi, full, sa, sb, sr;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    ai   = int'(a) & mask;
    bi   = int'(b) & mask;
    full = ai - bi - int'(bin);
    d    = 8'(full & mask);
    bo   = (full < 0);
    sa   = (ai >= half) ? ai - (1 << w) : ai;
    sb   = (bi >= half) ? bi - (1 << w) : bi;
    sr   = sa - sb - int'(bin);
    ov   = (sr < -half) || (sr > half - 1);
    z    = ((full & mask) == 0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after an accepting edge; pulseAt re-asserts start mid-run, dropAt releases a held start.
  task automatic waitDone(input int sel, input int pulseAt, input int dropAt);
    logic [7:0] diffStart;
    logic [2:0] fl;
    gotCycles = 0; gotBusy = 0; gotDone = 1'b0; diffMoved = 1'b0; overlap = 1'b0;
    diffStart = rdDiff(sel);
    for (int i = 0; i < 40 && !gotDone; i++) begin
      if (rdBusy(sel)) gotBusy++;
      @(posedge clk); #1;
      gotCycles++;
      if (rdBusy(sel) && rdDone(sel)) overlap = 1'b1;
      if (rdDone(sel)) gotDone = 1'b1;
      else if (rdDiff(sel) !== diffStart) diffMoved = 1'b1;
      if (gotCycles == pulseAt) driveIn(sel, 1'b1, 8'hAA, 8'h11, 1'b1);
      else if (gotCycles == pulseAt + 1) driveIn(sel, 1'b0, 8'h00, 8'h00, 1'b0);
      if (gotCycles == dropAt) driveIn(sel, 1'b0, 8'h3C, 8'hC3, 1'b1);
    end
    fl = rdFlags(sel);
    gotDiff = rdDiff(sel);
    {gotBout, gotOvf, gotZero} = fl;
  endtask

  task automatic applyStimulus(input int sel, input logic [7:0] a, input logic [7:0] b,
                               input logic bin, input int pulseAt);
    @(negedge clk);
    driveIn(sel, 1'b1, a, b, bin);
    @(posedge clk); #1;
    driveIn(sel, 1'b0, ~a, ~b, ~bin);
    waitDone(sel, pulseAt, -1);
  endtask

  task automatic checkResult(input string tag, input logic [7:0] d, input logic bo, input logic ov,
                             input logic z, input int cyc, input int busyExp);
    checkOutput({tag, ".done"}, gotDone, 1);
    checkOutput({tag, ".diff"}, gotDiff, d);
    checkOutput({tag, ".bout"}, gotBout, bo);
    checkOutput({tag, ".ovf"}, gotOvf, ov);
    checkOutput({tag, ".zero"}, gotZero, z);
    checkOutput({tag, ".latency"}, gotCycles, cyc);
    checkOutput({tag, ".busyCycles"}, gotBusy, busyExp);
    checkOutput({tag, ".diffHold"}, diffMoved, 0);
    checkOutput({tag, ".busyDoneOverlap"}, overlap, 0);
  endtask

  initial begin
    logic [7:0] a, b, d;
    logic       bin, bo, ov, z, seen;
    int         sel;

    vecs[0]  = '{0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 8};
    vecs[1]  = '{0, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 8};
    vecs[2]  = '{0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 8};
    vecs[3]  = '{0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 8};
    vecs[4]  = '{0, 8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8};
    vecs[5]  = '{0, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 8};
    vecs[6]  = '{1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1};
    vecs[7]  = '{1, 8'h00, 8'h01, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 1};
    vecs[8]  = '{1, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{1, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1};
    vecs[10] = '{2, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 2};
    vecs[11] = '{2, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 2};

    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) driveIn(s, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      checkOutput($sformatf("reset%0d.busy", s), rdBusy(s), 0);
      checkOutput($sformatf("reset%0d.done", s), rdDone(s), 0);
      checkOutput($sformatf("reset%0d.diff", s), rdDiff(s), 0);
      checkOutput($sformatf("reset%0d.flags", s), rdFlags(s), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].bin, -1);
      checkResult($sformatf("vec%0d", i), vecs[i].diff, vecs[i].bout, vecs[i].ovf, vecs[i].zero,
                  vecs[i].cycles, vecs[i].cycles);
    end

    applyStimulus(0, 8'h05, 8'h03, 1'b0, 3);
    checkResult("repulse", 8'h02, 1'b0, 1'b0, 1'b0, 8, 8);

    // Reset mid-run: outputs clear at once and the aborted op never completes.
    @(negedge clk);
    driveIn(0, 1'b1, 8'h40, 8'h01, 1'b0);
    @(posedge clk); #1;
    driveIn(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midrun.busyBefore", rdBusy(0), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrun.busy", rdBusy(0), 0);
    checkOutput("midrun.done", rdDone(0), 0);
    checkOutput("midrun.diff", rdDiff(0), 0);
    checkOutput("midrun.flags", rdFlags(0), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rdDone(0) || rdBusy(0)) seen = 1'b1;
    end
    checkOutput("midrun.noDone", seen, 0);
    applyStimulus(0, 8'h40, 8'h01, 1'b0, -1);
    checkResult("afterReset", 8'h3F, 1'b0, 1'b0, 1'b0, 8, 8);

    // Start held through DONE: second op accepted on the edge leaving DONE.
    @(negedge clk);
    driveIn(0, 1'b1, 8'h05, 8'h03, 1'b0);
    @(posedge clk); #1;
    driveIn(0, 1'b1, 8'h10, 8'h20, 1'b0);
    waitDone(0, -1, -1);
    checkResult("b2bFirst", 8'h02, 1'b0, 1'b0, 1'b0, 8, 8);
    waitDone(0, -1, 1);
    checkResult("b2bSecond", 8'hF0, 1'b1, 1'b0, 1'b0, 9, 8);

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 2));
      a   = 8'($urandom);
      b   = 8'($urandom);
      bin = 1'($urandom);
      refModel(widthOf(sel), a, b, bin, d, bo, ov, z);
      applyStimulus(sel, a, b, bin, -1);
      checkResult($sformatf("rand%0d", i), d, bo, ov, z, latencyOf(sel), latencyOf(sel));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
